// File: rtl/move_dispatcher.sv
// move_dispatcher
//   Initiator side of the board_validator piece-checker handshake. A move request
//   is latched together with a snapshot of the board, pre-checked for ownership and
//   destination legality, then handed to one piece checker by releasing chk_rst_n.
//   Once the checker answers, sliding pieces (bishop, rook, queen) get a path scan
//   over the latched board. A single verdict strobe closes every accepted request.
// Ports
//   CLOCK_50, reset_n         clock, asynchronous active-low reset
//   move_req, turn            request pulse (sampled in IDLE only), side to move
//   old_x/old_y/new_x/new_y   source and destination squares
//   board_in[y][x]            [3] colour (1 black), [2:0] piece code
//   chk_rst_n                 checker run enable (low holds the checker idle)
//   chk_old_x .. chk_new_y    latched coordinates presented to the checker
//   chk_h_delta, chk_v_delta  absolute coordinate differences
//   chk_piece_type            source square contents at latch time
//   chk_move_valid, chk_done  checker verdict and completion level
//   busy                      high whenever a request is in flight
//   move_done                 one-cycle verdict strobe
//   move_ok, move_timeout     verdict flags, held until the next accepted request
module move_dispatcher #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       move_req,
  input  logic       turn,
  input  logic [2:0] old_x,
  input  logic [2:0] old_y,
  input  logic [2:0] new_x,
  input  logic [2:0] new_y,
  input  logic [3:0] board_in [0:7][0:7],
  output logic       chk_rst_n,
  output logic [2:0] chk_old_x,
  output logic [2:0] chk_old_y,
  output logic [2:0] chk_new_x,
  output logic [2:0] chk_new_y,
  output logic [2:0] chk_h_delta,
  output logic [2:0] chk_v_delta,
  output logic [3:0] chk_piece_type,
  input  logic       chk_move_valid,
  input  logic       chk_done,
  output logic       busy,
  output logic       move_done,
  output logic       move_ok,
  output logic       move_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRECHECK = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_WAIT     = 3'd3,
    ST_SCAN     = 3'd4,
    ST_RESULT   = 3'd5
  } state_t;

  localparam logic [3:0] TIMEOUT_LOAD = 4'(TIMEOUT_CYCLES);

  state_t     state_r, next_state_s;
  logic       turn_r;
  logic [3:0] board_r [0:7][0:7];
  logic [2:0] old_x_r, old_y_r, new_x_r, new_y_r;
  logic [2:0] h_delta_r, v_delta_r;
  logic [3:0] piece_r;
  logic [2:0] cur_x_r, cur_y_r;
  logic [3:0] cnt_r;
  logic       chk_rst_n_r, busy_r, move_done_r, move_ok_r, move_timeout_r;

  logic       accept_s, pre_fail_s, slide_s, at_end_s, ok_s, timeout_s;
  logic [3:0] src_s, dst_s, cur_sq_s;

  function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // One unit step toward the target; an axis already on target stays put, so the
  // cursor can never run past the destination or wrap.
  function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] tgt);
    if (cur < tgt) begin
      return cur + 3'd1;
    end else if (cur > tgt) begin
      return cur - 3'd1;
    end else begin
      return cur;
    end
  endfunction

  // Next-state and verdict decode.
  always_comb begin
    next_state_s = state_r;
    ok_s         = 1'b0;
    timeout_s    = 1'b0;
    accept_s     = (state_r == ST_IDLE) && move_req;
    src_s        = board_r[old_y_r][old_x_r];
    dst_s        = board_r[new_y_r][new_x_r];
    cur_sq_s     = board_r[cur_y_r][cur_x_r];
    pre_fail_s   = (src_s[2:0] == 3'd0) || (src_s[3] != turn_r) ||
                   ((old_x_r == new_x_r) && (old_y_r == new_y_r)) ||
                   ((dst_s[2:0] != 3'd0) && (dst_s[3] == turn_r));
    slide_s      = (piece_r[2:0] == 3'd3) || (piece_r[2:0] == 3'd4) || (piece_r[2:0] == 3'd5);
    at_end_s     = (cur_x_r == new_x_r) && (cur_y_r == new_y_r);
    case (state_r)
      ST_IDLE: begin
        if (move_req) begin
          next_state_s = ST_PRECHECK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PRECHECK: begin
        if (pre_fail_s) begin
          next_state_s = ST_RESULT;
        end else begin
          next_state_s = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // chk_done outranks an expiring counter in the same cycle.
        if (chk_done) begin
          if (!chk_move_valid) begin
            next_state_s = ST_RESULT;
          end else if (slide_s) begin
            next_state_s = ST_SCAN;
          end else begin
            next_state_s = ST_RESULT;
            ok_s         = 1'b1;
          end
        end else if (cnt_r == 4'd1) begin
          // The counter reaches zero at the end of this cycle.
          next_state_s = ST_RESULT;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_SCAN: begin
        // The destination itself is never inspected; capture legality is the checker's job.
        if (at_end_s) begin
          next_state_s = ST_RESULT;
          ok_s         = 1'b1;
        end else if (cur_sq_s[2:0] != 3'd0) begin
          next_state_s = ST_RESULT;
        end else begin
          next_state_s = ST_SCAN;
        end
      end
      ST_RESULT: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request capture, timeout counter and scan cursor.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      turn_r    <= 1'b0;
      old_x_r   <= 3'd0;
      old_y_r   <= 3'd0;
      new_x_r   <= 3'd0;
      new_y_r   <= 3'd0;
      h_delta_r <= 3'd0;
      v_delta_r <= 3'd0;
      piece_r   <= 4'd0;
      cnt_r     <= 4'd0;
      cur_x_r   <= 3'd0;
      cur_y_r   <= 3'd0;
      for (int y = 0; y < 8; y++) begin
        for (int x = 0; x < 8; x++) begin
          board_r[y][x] <= 4'd0;
        end
      end
    end else begin
      if (accept_s) begin
        turn_r    <= turn;
        old_x_r   <= old_x;
        old_y_r   <= old_y;
        new_x_r   <= new_x;
        new_y_r   <= new_y;
        h_delta_r <= abs_diff(new_x, old_x);
        v_delta_r <= abs_diff(new_y, old_y);
        piece_r   <= board_in[old_y][old_x];
        board_r   <= board_in;
      end
      if (state_r == ST_LAUNCH) begin
        cnt_r <= TIMEOUT_LOAD;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end
      // The cursor is primed one step from the source while waiting, ready for SCAN.
      if (state_r == ST_WAIT) begin
        cur_x_r <= step_toward(old_x_r, new_x_r);
        cur_y_r <= step_toward(old_y_r, new_y_r);
      end else if (state_r == ST_SCAN) begin
        cur_x_r <= step_toward(cur_x_r, new_x_r);
        cur_y_r <= step_toward(cur_y_r, new_y_r);
      end
    end
  end

  // Registered handshake and verdict outputs, decoded from the next state.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      chk_rst_n_r    <= 1'b0;
      busy_r         <= 1'b0;
      move_done_r    <= 1'b0;
      move_ok_r      <= 1'b0;
      move_timeout_r <= 1'b0;
    end else begin
      chk_rst_n_r <= (next_state_s == ST_LAUNCH) || (next_state_s == ST_WAIT);
      busy_r      <= (next_state_s != ST_IDLE);
      move_done_r <= (next_state_s == ST_RESULT);
      if (accept_s) begin
        move_ok_r      <= 1'b0;
        move_timeout_r <= 1'b0;
      end else if (next_state_s == ST_RESULT) begin
        move_ok_r      <= ok_s;
        move_timeout_r <= timeout_s;
      end
    end
  end

  assign chk_rst_n      = chk_rst_n_r;
  assign chk_old_x      = old_x_r;
  assign chk_old_y      = old_y_r;
  assign chk_new_x      = new_x_r;
  assign chk_new_y      = new_y_r;
  assign chk_h_delta    = h_delta_r;
  assign chk_v_delta    = v_delta_r;
  assign chk_piece_type = piece_r;
  assign busy           = busy_r;
  assign move_done      = move_done_r;
  assign move_ok        = move_ok_r;
  assign move_timeout   = move_timeout_r;

endmodule

// File: tb/tb_move_dispatcher.sv
// tb_move_dispatcher
//   Drives move_dispatcher with directed and random moves against a stub piece
//   checker, and compares every cycle of each transaction with a behavioural model
//   that predicts verdict, latency and checker-enable window from the move rules.
module tb_move_dispatcher;

  localparam int TMO = 15;

  logic       CLOCK_50;
  logic       reset_n;
  logic       move_req;
  logic       turn;
  logic [2:0] old_x, old_y, new_x, new_y;
  logic [3:0] board_in [0:7][0:7];
  logic       chk_rst_n;
  logic [2:0] chk_old_x, chk_old_y, chk_new_x, chk_new_y;
  logic [2:0] chk_h_delta, chk_v_delta;
  logic [3:0] chk_piece_type;
  logic       chk_move_valid;
  logic       chk_done;
  logic       busy, move_done, move_ok, move_timeout;

  // stub checker controls and state
  logic       stub_valid = 1'b0;
  logic       stub_never = 1'b0;
  int         stub_delay = 2;
  int         scnt = 0;
  logic       sdone = 1'b0;
  logic       stray = 1'b0;

  logic [3:0] mb [0:7][0:7];  // board snapshot for the model
  int         n_pass = 0;
  int         n_total = 0;
  int         move_no = 0;

  move_dispatcher #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .move_req(move_req), .turn(turn),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y), .board_in(board_in),
    .chk_rst_n(chk_rst_n), .chk_old_x(chk_old_x), .chk_old_y(chk_old_y),
    .chk_new_x(chk_new_x), .chk_new_y(chk_new_y), .chk_h_delta(chk_h_delta),
    .chk_v_delta(chk_v_delta), .chk_piece_type(chk_piece_type),
    .chk_move_valid(chk_move_valid), .chk_done(chk_done), .busy(busy),
    .move_done(move_done), .move_ok(move_ok), .move_timeout(move_timeout)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Stub checker: done rises stub_delay cycles after release, held until reset.
  always @(posedge CLOCK_50) begin
    if (!chk_rst_n) begin
      scnt  <= 0;
      sdone <= 1'b0;
    end else begin
      scnt  <= scnt + 1;
      sdone <= !stub_never && (scnt + 1 >= stub_delay);
    end
  end

  // Stray done pulses while the checker is held must be ignored by the DUT.
  assign chk_done       = sdone | (stray & ~chk_rst_n);
  assign chk_move_valid = stub_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (move %0d)", name, act, exp, move_no);
    end
  endtask

  // Predicts result cycle L (request is cycle 0), verdict, timeout and the last
  // cycle w with the checker released (0 if never released).
  task automatic model(input int ox, input int oy, input int nx, input int ny,
                       input bit trn, input bit sv, input int sd, input bit never,
                       output int L, output bit ok, output bit to, output int w);
    logic [3:0] src, dst;
    int dx, dy, ax, ay, n, blk, sx, sy, x, y;
    src = mb[oy][ox];
    dst = mb[ny][nx];
    ok = 1'b0; to = 1'b0; w = 0; L = 2;
    if (src[2:0] == 3'd0 || src[3] != trn || (ox == nx && oy == ny) ||
        (dst[2:0] != 3'd0 && dst[3] == trn)) begin
      L = 2;
    end else if (never || sd > TMO) begin
      w = 2 + TMO; L = w + 1; to = 1'b1;
    end else begin
      w = 2 + sd; L = w + 1;
      if (sv) begin
        if (src[2:0] == 3'd3 || src[2:0] == 3'd4 || src[2:0] == 3'd5) begin
          dx = nx - ox; dy = ny - oy;
          ax = (dx < 0) ? -dx : dx; ay = (dy < 0) ? -dy : dy;
          sx = (dx > 0) ? 1 : ((dx < 0) ? -1 : 0);
          sy = (dy > 0) ? 1 : ((dy < 0) ? -1 : 0);
          n = (ax > ay) ? ax : ay;
          blk = 0;
          for (int i = 1; i < n; i++) begin
            x = ox + sx * ((i < ax) ? i : ax);
            y = oy + sy * ((i < ay) ? i : ay);
            if (blk == 0 && mb[y][x][2:0] != 3'd0) blk = i;
          end
          if (blk != 0) begin
            L = w + 1 + blk;
          end else begin
            L = w + 1 + n; ok = 1'b1;
          end
        end else begin
          ok = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        board_in[y][x] = 4'd0;
  endtask

  task automatic run_move(input int ox, input int oy, input int nx, input int ny,
                          input bit trn, input bit sv, input int sd, input bit never,
                          input int pin_L, input int pin_ok, input int pin_to,
                          input int reset_at, input bit force_pulse);
    int L, w;
    bit ok, to;
    logic [2:0] ehd, evd;
    move_no++;
    old_x = 3'(ox); old_y = 3'(oy); new_x = 3'(nx); new_y = 3'(ny);
    turn = trn; stub_valid = sv; stub_delay = sd; stub_never = never;
    mb = board_in;
    ehd = 3'((nx > ox) ? nx - ox : ox - nx);
    evd = 3'((ny > oy) ? ny - oy : oy - ny);
    move_req = 1'b1; stray = 1'b0;
    model(ox, oy, nx, ny, trn, sv, sd, never, L, ok, to, w);
    if (pin_L >= 0) begin
      check("pin_latency", L, pin_L);
      check("pin_ok", {31'd0, ok}, pin_ok);
      check("pin_timeout", {31'd0, to}, pin_to);
    end
    @(negedge CLOCK_50);
    move_req = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      if (k == reset_at) begin
        move_req = 1'b0; stray = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_move_done", move_done, 0);
        check("rst_move_ok", move_ok, 0);
        check("rst_move_timeout", move_timeout, 0);
        check("rst_chk_rst_n", chk_rst_n, 0);
        check("rst_chk_new_y", chk_new_y, 0);
        check("rst_chk_v_delta", chk_v_delta, 0);
        check("rst_chk_piece", chk_piece_type, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge CLOCK_50);
          check("post_rst_busy", busy, 0);
          check("post_rst_move_done", move_done, 0);
          check("post_rst_chk_rst_n", chk_rst_n, 0);
        end
        break;
      end
      check("busy", busy, k <= L);
      check("move_done", move_done, k == L);
      check("chk_rst_n", chk_rst_n, (w != 0) && (k >= 2) && (k <= w));
      check("move_ok", move_ok, (k >= L) ? {31'd0, ok} : 32'd0);
      check("move_timeout", move_timeout, (k >= L) ? {31'd0, to} : 32'd0);
      check("chk_old_x", chk_old_x, ox);
      check("chk_old_y", chk_old_y, oy);
      check("chk_new_x", chk_new_x, nx);
      check("chk_new_y", chk_new_y, ny);
      check("chk_h_delta", chk_h_delta, ehd);
      check("chk_v_delta", chk_v_delta, evd);
      check("chk_piece_type", chk_piece_type, mb[oy][ox]);
      if (k < L) begin
        // Disturb inputs while busy: all of it must be ignored.
        move_req = (force_pulse && k == 2) || ($urandom_range(0, 3) == 0);
        old_x = 3'($urandom_range(0, 7)); new_y = 3'($urandom_range(0, 7));
        turn = $urandom_range(0, 1);
        board_in[$urandom_range(0, 7)][$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
        stray = $urandom_range(0, 1);
      end else begin
        move_req = 1'b0; stray = 1'b0;
      end
      @(negedge CLOCK_50);
    end
  endtask

  task automatic random_move();
    int ox, oy, nx, ny, p, k, dxs, dys, sd;
    bit trn, sv, nev;
    trn = $urandom_range(0, 1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        board_in[y][x] = ($urandom_range(0, 99) < 30) ?
                         {1'($urandom_range(0, 1)), 3'($urandom_range(1, 6))} : 4'd0;
    ox = $urandom_range(0, 7); oy = $urandom_range(0, 7);
    p = $urandom_range(0, 19);
    board_in[oy][ox] = (p == 0) ? 4'd0 : {((p == 1) ? ~trn : trn), 3'($urandom_range(1, 6))};
    nx = $urandom_range(0, 7); ny = $urandom_range(0, 7);
    if ($urandom_range(0, 1) == 1) begin
      dxs = $urandom_range(0, 2) - 1; dys = $urandom_range(0, 2) - 1;
      k = $urandom_range(1, 7);
      if ((dxs != 0 || dys != 0) && ox + dxs * k >= 0 && ox + dxs * k <= 7 &&
          oy + dys * k >= 0 && oy + dys * k <= 7) begin
        nx = ox + dxs * k; ny = oy + dys * k;
      end
    end
    sv  = ($urandom_range(0, 3) != 0);
    nev = ($urandom_range(0, 9) == 0);
    sd  = $urandom_range(1, 17);
    run_move(ox, oy, nx, ny, trn, sv, sd, nev, -1, 0, 0, -1, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; move_req = 1'b0; turn = 1'b0;
    old_x = 3'd0; old_y = 3'd0; new_x = 3'd0; new_y = 3'd0;
    clear_board();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check("reset_busy", busy, 0);
    check("reset_chk_rst_n", chk_rst_n, 0);
    check("reset_move_done", move_done, 0);
    check("reset_move_ok", move_ok, 0);
    check("reset_move_timeout", move_timeout, 0);
    check("reset_chk_piece", chk_piece_type, 0);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    check("idle_busy", busy, 0);

    // 1: white rook (0,0)->(0,5) on an empty column, checker valid after 2 cycles
    clear_board(); board_in[0][0] = 4'h4;
    run_move(0, 0, 0, 5, 1'b0, 1'b1, 2, 1'b0, 10, 1, 0, -1, 1'b0);
    // 2: same with a black pawn on (0,3)
    clear_board(); board_in[0][0] = 4'h4; board_in[3][0] = 4'h9;
    run_move(0, 0, 0, 5, 1'b0, 1'b1, 2, 1'b0, 8, 0, 0, -1, 1'b0);
    // 3: black to move, white piece on the source
    clear_board(); board_in[0][0] = 4'h4;
    run_move(0, 0, 0, 5, 1'b1, 1'b1, 2, 1'b0, 2, 0, 0, -1, 1'b0);
    // 4: checker never answers
    clear_board(); board_in[0][0] = 4'h4;
    run_move(0, 0, 0, 5, 1'b0, 1'b1, 2, 1'b1, 18, 0, 1, -1, 1'b0);
    // 5: knight (1,0)->(2,2) with a request pulsed while busy
    clear_board(); board_in[0][1] = 4'h2;
    run_move(1, 0, 2, 2, 1'b0, 1'b1, 2, 1'b0, 5, 1, 0, -1, 1'b1);
    // 6: reset during the scan of move 1
    clear_board(); board_in[0][0] = 4'h4;
    run_move(0, 0, 0, 5, 1'b0, 1'b1, 2, 1'b0, 10, 1, 0, 7, 1'b0);
    // checker rejects a bishop move: no scan
    clear_board(); board_in[2][2] = 4'hB;
    run_move(2, 2, 5, 5, 1'b1, 1'b0, 3, 1'b0, 6, 0, 0, -1, 1'b0);
    // own piece on destination
    clear_board(); board_in[1][1] = 4'h5; board_in[4][1] = 4'h1;
    run_move(1, 1, 1, 4, 1'b0, 1'b1, 2, 1'b0, 2, 0, 0, -1, 1'b0);
    // last-possible answer (15 cycles) beats the timeout; adjacent queen step
    clear_board(); board_in[3][3] = 4'h5;
    run_move(3, 3, 4, 4, 1'b0, 1'b1, 15, 1'b0, 19, 1, 0, -1, 1'b0);

    for (int i = 0; i < 150; i++) random_move();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
